// File: rtl/spi_master_arbiter_if.sv
// Requester-side and SPI-side signals of spi_master_arbiter, grouped into one bundle.
// The master modport is the arbiter's view; the slave modport is the requesters/SPI slave view.
interface spi_master_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic [1:0]           req;
    logic [1:0]           cmd0;
    logic [1:0]           cmd1;
    logic [ADDR_SIZE-1:0] din0;
    logic [ADDR_SIZE-1:0] din1;
    logic [1:0]           ack;
    logic [ADDR_SIZE-1:0] rdata;
    logic                 rdata_valid;
    logic                 busy;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;

    modport master (
        input  req, cmd0, cmd1, din0, din1, MISO,
        output ack, rdata, rdata_valid, busy, SS_n, MOSI
    );

    modport slave (
        output req, cmd0, cmd1, din0, din1, MISO,
        input  ack, rdata, rdata_valid, busy, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI slave between two requesters; serialises {cmd, din}
// frames on SS_n/MOSI and captures MISO for read-data, locking the channel across a read pair.
module spi_master_arbiter #(
    parameter int MEM_DEPTH = 256,
    parameter int RD_LAT    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_master_arbiter_if.master bus
);
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
    localparam int FrameW    = ADDR_SIZE + 2;
    localparam int CntMax    = (FrameW > RD_LAT) ? FrameW : RD_LAT;
    localparam int CntW      = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StStart, StShift, StWait, StCapture, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [FrameW-1:0]    frame_q, frame_d;
    logic [1:0]           cmd_q, cmd_d;
    logic                 owner_q, owner_d;
    logic                 lock_q, lock_d;
    logic                 lock_owner_q, lock_owner_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [ADDR_SIZE-1:0] rdata_sr_q, rdata_sr_d;
    logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic [1:0]           ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;

    logic                 gnt_valid;
    logic                 gnt_idx;
    logic [1:0]           lock_cmd;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        cmd_d         = cmd_q;
        owner_d       = owner_q;
        lock_d        = lock_q;
        lock_owner_d  = lock_owner_q;
        rr_ptr_d      = rr_ptr_q;
        rdata_sr_d    = rdata_sr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        ack_d         = 2'b00;
        busy_d        = busy_q;
        ss_n_d        = ss_n_q;
        mosi_d        = mosi_q;
        gnt_valid     = 1'b0;
        gnt_idx       = 1'b0;
        lock_cmd      = lock_owner_q ? bus.cmd1 : bus.cmd0;

        case (state_q)
            StIdle: begin
                // While locked only the owner's read-data may use the channel.
                if (lock_q) begin
                    if (bus.req[lock_owner_q] && (lock_cmd == 2'b11)) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = lock_owner_q;
                    end
                end else begin
                    case (bus.req)
                        2'b01:   begin gnt_valid = 1'b1; gnt_idx = 1'b0;     end
                        2'b10:   begin gnt_valid = 1'b1; gnt_idx = 1'b1;     end
                        2'b11:   begin gnt_valid = 1'b1; gnt_idx = rr_ptr_q; end
                        default: ;
                    endcase
                end
                if (gnt_valid) begin
                    frame_d  = gnt_idx ? {bus.cmd1, bus.din1} : {bus.cmd0, bus.din0};
                    cmd_d    = gnt_idx ? bus.cmd1 : bus.cmd0;
                    owner_d  = gnt_idx;
                    rr_ptr_d = ~gnt_idx;
                    busy_d   = 1'b1;
                    ss_n_d   = 1'b0;
                    mosi_d   = cmd_d[1];
                    cnt_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    mosi_d  = frame_q[FrameW-1];
                    frame_d = frame_q << 1;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == CntW'(FrameW - 1)) begin
                    mosi_d = 1'b0;
                    cnt_d  = '0;
                    if (cmd_q == 2'b11) begin
                        state_d = (RD_LAT > 1) ? StWait : StCapture;
                    end else begin
                        state_d    = StDone;
                        ss_n_d     = 1'b1;
                        busy_d     = 1'b0;
                        ack_d[owner_q] = 1'b1;
                    end
                end else begin
                    mosi_d  = frame_q[FrameW-1];
                    frame_d = frame_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == CntW'(RD_LAT - 2)) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                rdata_sr_d = {rdata_sr_q[ADDR_SIZE-2:0], bus.MISO};
                if (cnt_q == CntW'(ADDR_SIZE - 1)) begin
                    // Final sample goes straight into rdata so it lands together with ack.
                    rdata_d        = rdata_sr_d;
                    rdata_valid_d  = 1'b1;
                    state_d        = StDone;
                    ss_n_d         = 1'b1;
                    busy_d         = 1'b0;
                    ack_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (cmd_q == 2'b10) begin
                    lock_d       = 1'b1;
                    lock_owner_d = owner_q;
                end else if ((cmd_q == 2'b11) && lock_q && (lock_owner_q == owner_q)) begin
                    lock_d = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            frame_q       <= '0;
            cmd_q         <= 2'b00;
            owner_q       <= 1'b0;
            lock_q        <= 1'b0;
            lock_owner_q  <= 1'b0;
            rr_ptr_q      <= 1'b0;
            rdata_sr_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            ack_q         <= 2'b00;
            busy_q        <= 1'b0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            cmd_q         <= cmd_d;
            owner_q       <= owner_d;
            lock_q        <= lock_d;
            lock_owner_q  <= lock_owner_d;
            rr_ptr_q      <= rr_ptr_d;
            rdata_sr_q    <= rdata_sr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.busy        = busy_q;
    assign bus.SS_n        = ss_n_q;
    assign bus.MOSI        = mosi_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: default instance plus a RD_LAT=1, MEM_DEPTH=16 instance.
module tb_spi_master_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_arbiter_if #(.ADDR_SIZE(8)) ifa ();
    spi_master_arbiter_if #(.ADDR_SIZE(4)) ifb ();

    spi_master_arbiter #(.MEM_DEPTH(256), .RD_LAT(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    spi_master_arbiter #(.MEM_DEPTH(16), .RD_LAT(1)) u_dut_p (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         f_len;
    logic [11:0] f_mosi;
    logic [1:0] f_ack_seen;
    logic       f_rv_seen;
    logic       f_busy_all;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request on the default instance and follow it until SS_n rises again.
    // Returns at the negedge of the DONE cycle with req dropped.
    task automatic do_frame(input int idx, input logic [1:0] cmd, input logic [7:0] din,
                            input logic [7:0] miso_byte);
        int w;
        int t;
        ifa.req[idx] = 1'b1;
        if (idx == 0) begin ifa.cmd0 = cmd; ifa.din0 = din; end
        else          begin ifa.cmd1 = cmd; ifa.din1 = din; end
        w = 0;
        @(negedge clk);
        while (ifa.SS_n && w < 60) begin w++; @(negedge clk); end
        check_eq("frame_start", {31'd0, ifa.SS_n}, 32'd0);
        t = 0; f_mosi = '0; f_ack_seen = '0; f_rv_seen = 1'b0; f_busy_all = 1'b1;
        while (!ifa.SS_n && t < 60) begin
            if (t < 12) f_mosi = {f_mosi[10:0], ifa.MOSI};
            f_ack_seen |= ifa.ack;
            f_rv_seen  |= ifa.rdata_valid;
            f_busy_all &= ifa.busy;
            if (t >= 14 && t < 22) ifa.MISO = miso_byte[21-t];
            else                   ifa.MISO = 1'b0;
            t++;
            @(negedge clk);
        end
        f_len = t;
        ifa.req[idx] = 1'b0;
        ifa.MISO = 1'b0;
    endtask

    logic [1:0] ack_seq [4];
    int k, cyc, hi, min_gap, low_cnt, w, t;
    logic seen_low;
    logic [7:0] mosi8;

    initial begin
        rst = 1'b1;
        ifa.req = '0; ifa.cmd0 = '0; ifa.cmd1 = '0; ifa.din0 = '0; ifa.din1 = '0; ifa.MISO = 1'b0;
        ifb.req = '0; ifb.cmd0 = '0; ifb.cmd1 = '0; ifb.din0 = '0; ifb.din1 = '0; ifb.MISO = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ss_n", {31'd0, ifa.SS_n}, 32'd1);
        check_eq("rst_mosi", {31'd0, ifa.MOSI}, 32'd0);
        check_eq("rst_ack", {30'd0, ifa.ack}, 32'd0);
        check_eq("rst_rdata", {24'd0, ifa.rdata}, 32'd0);
        check_eq("rst_rvalid", {31'd0, ifa.rdata_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, ifa.busy}, 32'd0);
        check_eq("rst_p_ss_n", {31'd0, ifb.SS_n}, 32'd1);
        rst = 1'b0;

        // Write-addr 0xA5 from requester 0
        do_frame(0, 2'b00, 8'hA5, 8'h00);
        check_eq("wr_len", f_len, 32'd12);
        check_eq("wr_mosi", {20'd0, f_mosi}, 32'h0A5);
        check_eq("wr_ack_early", {30'd0, f_ack_seen}, 32'd0);
        check_eq("wr_busy", {31'd0, f_busy_all}, 32'd1);
        check_eq("wr_ack", {30'd0, ifa.ack}, 32'd1);
        check_eq("wr_busy_done", {31'd0, ifa.busy}, 32'd0);
        check_eq("wr_rvalid", {31'd0, ifa.rdata_valid | f_rv_seen}, 32'd0);
        @(negedge clk);
        check_eq("wr_ack_pulse", {30'd0, ifa.ack}, 32'd0);

        // Read-addr 0x3C then read-data 0xC7 from requester 1
        do_frame(1, 2'b10, 8'h3C, 8'h00);
        check_eq("ra_len", f_len, 32'd12);
        check_eq("ra_mosi", {20'd0, f_mosi}, 32'hE3C);
        check_eq("ra_ack", {30'd0, ifa.ack}, 32'd2);
        do_frame(1, 2'b11, 8'h00, 8'hC7);
        check_eq("rd_len", f_len, 32'd22);
        check_eq("rd_mosi", {20'd0, f_mosi}, 32'hF00);
        check_eq("rd_ack", {30'd0, ifa.ack}, 32'd2);
        check_eq("rd_rvalid", {31'd0, ifa.rdata_valid}, 32'd1);
        check_eq("rd_rvalid_early", {31'd0, f_rv_seen}, 32'd0);
        check_eq("rd_rdata", {24'd0, ifa.rdata}, 32'hC7);
        @(negedge clk);
        check_eq("rd_rvalid_pulse", {31'd0, ifa.rdata_valid}, 32'd0);
        // Unlocked again: requester 0 gets a write through, rdata holds
        do_frame(0, 2'b01, 8'h55, 8'h00);
        check_eq("unlock_len", f_len, 32'd12);
        check_eq("unlock_ack", {30'd0, ifa.ack}, 32'd1);
        check_eq("rdata_hold", {24'd0, ifa.rdata}, 32'hC7);

        // Contention from a fresh rr pointer
        pulse_reset();
        ifa.cmd0 = 2'b00; ifa.din0 = 8'h11;
        ifa.cmd1 = 2'b01; ifa.din1 = 8'h22;
        ifa.req = 2'b11;
        for (int i = 0; i < 4; i++) ack_seq[i] = 2'b00;
        k = 0; cyc = 0; hi = 0; min_gap = 99; seen_low = 1'b0;
        while (k < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ifa.ack != 2'b00) begin ack_seq[k] = ifa.ack; k++; end
            if (ifa.SS_n) hi++;
            else begin
                if (hi > 0) begin
                    if (seen_low && hi < min_gap) min_gap = hi;
                    hi = 0;
                end
                seen_low = 1'b1;
            end
        end
        ifa.req = 2'b00;
        check_eq("cont_acks", k, 32'd4);
        check_eq("cont_ack0", {30'd0, ack_seq[0]}, 32'd1);
        check_eq("cont_ack1", {30'd0, ack_seq[1]}, 32'd2);
        check_eq("cont_ack2", {30'd0, ack_seq[2]}, 32'd1);
        check_eq("cont_ack3", {30'd0, ack_seq[3]}, 32'd2);
        check_eq("cont_gap", {31'd0, min_gap >= 1 && min_gap < 99}, 32'd1);

        // Lock: requester 1 read pair holds off requester 0's write-data
        do_frame(1, 2'b10, 8'h10, 8'h00);
        check_eq("lk_ra_ack", {30'd0, ifa.ack}, 32'd2);
        ifa.req[0] = 1'b1; ifa.cmd0 = 2'b01; ifa.din0 = 8'h77;
        low_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (!ifa.SS_n) low_cnt++;
        end
        check_eq("lk_holdoff", low_cnt, 32'd0);
        do_frame(1, 2'b11, 8'h00, 8'h5A);
        check_eq("lk_rd_ack", {30'd0, ifa.ack}, 32'd2);
        check_eq("lk_rd_len", f_len, 32'd22);
        check_eq("lk_rd_rdata", {24'd0, ifa.rdata}, 32'h5A);
        do_frame(0, 2'b01, 8'h77, 8'h00);
        check_eq("lk_wd_ack", {30'd0, ifa.ack}, 32'd1);
        check_eq("lk_wd_mosi", {20'd0, f_mosi}, 32'h177);

        // Reset at t=5 of a write, request stays up
        ifa.req[0] = 1'b1; ifa.cmd0 = 2'b00; ifa.din0 = 8'hFF;
        w = 0;
        @(negedge clk);
        while (ifa.SS_n && w < 60) begin w++; @(negedge clk); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_ss_n", {31'd0, ifa.SS_n}, 32'd1);
        check_eq("mrst_busy", {31'd0, ifa.busy}, 32'd0);
        check_eq("mrst_ack", {30'd0, ifa.ack}, 32'd0);
        check_eq("mrst_rdata", {24'd0, ifa.rdata}, 32'd0);
        rst = 1'b0;
        do_frame(0, 2'b00, 8'hFF, 8'h00);
        check_eq("mrst_len", f_len, 32'd12);
        check_eq("mrst_mosi", {20'd0, f_mosi}, 32'h0FF);
        check_eq("mrst_ack2", {30'd0, ifa.ack}, 32'd1);

        // Reset during a locked read-data clears the lock
        do_frame(1, 2'b10, 8'h20, 8'h00);
        ifa.req[1] = 1'b1; ifa.cmd1 = 2'b11; ifa.din1 = 8'h00;
        w = 0;
        @(negedge clk);
        while (ifa.SS_n && w < 60) begin w++; @(negedge clk); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ifa.req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_frame(0, 2'b00, 8'h05, 8'h00);
        check_eq("lrst_len", f_len, 32'd12);
        check_eq("lrst_ack", {30'd0, ifa.ack}, 32'd1);

        // Small instance: read-data with RD_LAT=1, 4-bit address
        ifb.req[0] = 1'b1; ifb.cmd0 = 2'b11; ifb.din0 = 4'h0;
        w = 0;
        @(negedge clk);
        while (ifb.SS_n && w < 60) begin w++; @(negedge clk); end
        check_eq("p_start", {31'd0, ifb.SS_n}, 32'd0);
        t = 0; mosi8 = '0;
        while (!ifb.SS_n && t < 40) begin
            if (t < 8) mosi8 = {mosi8[6:0], ifb.MOSI};
            case (t)
                8:       ifb.MISO = 1'b1;
                9:       ifb.MISO = 1'b0;
                10:      ifb.MISO = 1'b1;
                11:      ifb.MISO = 1'b1;
                default: ifb.MISO = 1'b0;
            endcase
            t++;
            @(negedge clk);
        end
        ifb.req[0] = 1'b0;
        ifb.MISO = 1'b0;
        check_eq("p_len", t, 32'd12);
        check_eq("p_mosi", {24'd0, mosi8}, 32'hF0);
        check_eq("p_ack", {30'd0, ifb.ack}, 32'd1);
        check_eq("p_rvalid", {31'd0, ifb.rdata_valid}, 32'd1);
        check_eq("p_rdata", {28'd0, ifb.rdata}, 32'hB);
        @(negedge clk);
        check_eq("p_rvalid_pulse", {31'd0, ifb.rdata_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
